// File: rtl/pixel_write_buffer.sv
// Pixel write buffer: FIFO between the rasteriser and a single-outstanding framebuffer write port.
// Optional bounds checking against FB_PIXELS is enabled by defining PIXEL_WRITE_BUFFER_BOUNDS_CHECK_EN.
module pixel_write_buffer #(
    parameter int unsigned DEPTH     = 8,
    parameter logic [31:0] FB_BASE   = 32'h0000_0000,
    parameter int unsigned FB_PIXELS = 307200
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       pixel_valid,
    input  logic [18:0]                pixel_number,
    input  logic [31:0]                rgba,
    output logic                       pixel_ready,
    input  logic                       flush_req,
    output logic                       flush_done,
    output logic                       mem_write,
    output logic [31:0]                mem_addr,
    output logic [31:0]                mem_wdata,
    input  logic                       mem_ack,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic [15:0]                dropped
);

    localparam int unsigned   AW          = $clog2(DEPTH);
    localparam int unsigned   CW          = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);
    localparam logic [31:0]   FB_PIXELS_W = 32'(FB_PIXELS);
`ifdef PIXEL_WRITE_BUFFER_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    typedef struct packed {
        logic [18:0] pixel_number;
        logic [31:0] rgba;
    } entry_t;

    typedef enum logic {
        ST_IDLE,
        ST_REQ
    } state_e;

    entry_t        fifo_mem [DEPTH];
    entry_t        head;
    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          overflow_q, overflow_d;
    logic          flush_pending_q, flush_pending_d;
    logic          flush_done_q, flush_done_d;
    logic          flush_armed;
    logic          fifo_empty;
    logic          push_accept;
    logic          in_range;
    logic          push;
    logic          pop;

    assign fifo_empty  = (count_q == '0);
    assign pixel_ready = (count_q != FULL_COUNT);
    assign head        = fifo_mem[rd_ptr_q];

    // clear wins over a same-cycle push; an accepted out-of-range pixel is consumed but not queued.
    assign push_accept = pixel_valid && pixel_ready && !clear;
    assign in_range    = ({13'd0, pixel_number} < FB_PIXELS_W);
    assign push        = push_accept && (!BOUNDS_EN || in_range);
    // Pops use registered occupancy only, so a pixel pushed into an empty FIFO is issued one edge later.
    assign pop         = !clear && !fifo_empty && ((state_q == ST_IDLE) || mem_ack);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d         = state_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        overflow_d      = overflow_q;
        flush_pending_d = flush_pending_q;
        flush_done_d    = 1'b0;
        flush_armed     = flush_pending_q || flush_req;

        case (state_q)
            ST_IDLE: if (pop) state_d = ST_REQ;
            ST_REQ:  if (mem_ack && !pop) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (pop) begin
            mem_addr_d  = FB_BASE + {11'd0, head.pixel_number, 2'b00};
            mem_wdata_d = head.rgba;
            rd_ptr_d    = rd_ptr_q + AW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (pixel_valid && !pixel_ready) begin
            overflow_d = 1'b1;
        end

        if (clear) begin
            wr_ptr_d        = '0;
            rd_ptr_d        = '0;
            count_d         = '0;
            overflow_d      = 1'b0;
            flush_pending_d = 1'b0;
        end else begin
            // Judged on next-state values so the pulse lands in the cycle right after the last ack.
            flush_done_d    = flush_armed && (state_d == ST_IDLE) && (count_d == '0);
            flush_pending_d = flush_armed && !flush_done_d;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            overflow_q      <= 1'b0;
            flush_pending_q <= 1'b0;
            flush_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            overflow_q      <= overflow_d;
            flush_pending_q <= flush_pending_d;
            flush_done_q    <= flush_done_d;
        end
    end

    // NOTE: storage has no reset; pointers and count define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= '{pixel_number: pixel_number, rgba: rgba};
        end
    end

`ifdef PIXEL_WRITE_BUFFER_BOUNDS_CHECK_EN
    logic [15:0] dropped_q, dropped_d;

    always_comb begin
        dropped_d = dropped_q;
        if (push_accept && !in_range && (dropped_q != 16'hFFFF)) begin
            dropped_d = dropped_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dropped_q <= '0;
        end else begin
            dropped_q <= dropped_d;
        end
    end

    assign dropped = dropped_q;
`else
    assign dropped = '0;
`endif

    assign mem_write  = (state_q == ST_REQ);
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign flush_done = flush_done_q;

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Bench for pixel_write_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_pixel_write_buffer;

    localparam int unsigned DEPTH     = 8;
    localparam logic [31:0] FB_BASE   = 32'h0000_1000;
    localparam int unsigned FB_PIXELS = 307200;
    localparam int unsigned CW        = $clog2(DEPTH + 1);

    logic          clk;
    logic          reset;
    logic          clear;
    logic          pixel_valid;
    logic [18:0]   pixel_number;
    logic [31:0]   rgba;
    logic          pixel_ready;
    logic          flush_req;
    logic          flush_done;
    logic          mem_write;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ack;
    logic [CW-1:0] count;
    logic          overflow;
    logic [15:0]   dropped;

    pixel_write_buffer #(
        .DEPTH    (DEPTH),
        .FB_BASE  (FB_BASE),
        .FB_PIXELS(FB_PIXELS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .pixel_valid (pixel_valid),
        .pixel_number(pixel_number),
        .rgba        (rgba),
        .pixel_ready (pixel_ready),
        .flush_req   (flush_req),
        .flush_done  (flush_done),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .count       (count),
        .overflow    (overflow),
        .dropped     (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Memory-side log of every acknowledged write and the cycle it completed in.
    int unsigned cyc = 0;
    logic [63:0] wr_log [$];
    int unsigned wr_cyc [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset === 1'b0 && mem_write === 1'b1 && mem_ack === 1'b1) begin
            wr_log.push_back({mem_addr, mem_wdata});
            wr_cyc.push_back(cyc);
        end
    end

    // Reference model: a queue of waiting pixels plus the write currently presented to memory.
    logic [50:0] m_fifo [$];
    bit          m_busy;
    bit          m_ovf;
    bit          m_pend;
    bit          m_done;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    int unsigned m_dropped;
    int unsigned fd_cnt;

    function automatic logic [31:0] fb_addr(input logic [18:0] pn);
        return FB_BASE + (32'(pn) << 2);
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        m_busy    = 1'b0;
        m_ovf     = 1'b0;
        m_pend    = 1'b0;
        m_done    = 1'b0;
        m_addr    = '0;
        m_data    = '0;
        m_dropped = 0;
    endtask

    task automatic compare_all(input string where);
        check({where, ".mem_write"},   32'(mem_write),   32'(m_busy));
        check({where, ".mem_addr"},    mem_addr,         m_addr);
        check({where, ".mem_wdata"},   mem_wdata,        m_data);
        check({where, ".count"},       32'(count),       32'(m_fifo.size()));
        check({where, ".pixel_ready"}, 32'(pixel_ready), 32'(m_fifo.size() < DEPTH));
        check({where, ".overflow"},    32'(overflow),    32'(m_ovf));
        check({where, ".flush_done"},  32'(flush_done),  32'(m_done));
        check({where, ".dropped"},     32'(dropped),     m_dropped);
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare everything.
    task automatic tick(input bit v, input logic [18:0] pn, input logic [31:0] c,
                        input bit ack, input bit clr, input bit fr, input string where);
        bit          full_before;
        bit          accept;
        bit          keep;
        bit          can_pop;
        bit          pend;
        logic [50:0] hd;
        pixel_valid  = v;
        pixel_number = pn;
        rgba         = c;
        mem_ack      = ack;
        clear        = clr;
        flush_req    = fr;
        @(posedge clk);
        #1;
        full_before = (m_fifo.size() >= DEPTH);
        accept      = v && !full_before && !clr;
`ifdef PIXEL_WRITE_BUFFER_BOUNDS_CHECK_EN
        keep = accept && (32'(pn) < FB_PIXELS);
        if (accept && !keep && m_dropped < 32'hFFFF) m_dropped++;
`else
        keep = accept;
`endif
        can_pop = !clr && (m_fifo.size() > 0) && (!m_busy || ack);
        if (clr) begin
            m_fifo.delete();
        end else begin
            if (can_pop) begin
                hd     = m_fifo.pop_front();
                m_addr = fb_addr(hd[50:32]);
                m_data = hd[31:0];
            end
            if (keep) m_fifo.push_back({pn, c});
        end
        if (can_pop) m_busy = 1'b1;
        else if (ack) m_busy = 1'b0;
        m_ovf  = clr ? 1'b0 : (m_ovf || (v && full_before));
        pend   = m_pend || fr;
        m_done = !clr && pend && !m_busy && (m_fifo.size() == 0);
        m_pend = !clr && pend && !m_done;
        if (flush_done === 1'b1) fd_cnt++;
        compare_all(where);
    endtask

    task automatic idle(input bit ack, input string where);
        tick(1'b0, 19'd0, 32'd0, ack, 1'b0, 1'b0, where);
    endtask

    task automatic do_reset(input string where);
        reset        = 1'b1;
        pixel_valid  = 1'b0;
        clear        = 1'b0;
        flush_req    = 1'b0;
        mem_ack      = 1'b0;
        pixel_number = '0;
        rgba         = '0;
        #2;
        model_reset();
        compare_all(where);
        @(posedge clk);
        #1;
        reset = 1'b0;
        compare_all({where, ".rel"});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_c [20];
        logic [18:0] exp_p [20];
        logic [63:0] entry;

        fd_cnt = 0;
        do_reset("reset");
        check("reset.ready_const", 32'(pixel_ready), 32'd1);

`ifdef PIXEL_WRITE_BUFFER_BOUNDS_CHECK_EN
        wr_log.delete();
        tick(1'b1, 19'd307199, 32'h1111_2222, 1'b0, 1'b0, 1'b0, "bnd.in");
        tick(1'b1, 19'd307200, 32'h3333_4444, 1'b0, 1'b0, 1'b0, "bnd.out");
        for (int i = 0; i < 4; i++) idle(1'b1, "bnd.drain");
        check("bnd.writes", 32'(wr_log.size()), 32'd1);
        entry = (wr_log.size() > 0) ? wr_log[0] : 64'd0;
        check("bnd.addr", entry[63:32], 32'h0012_CFFC);
        check("bnd.dropped", 32'(dropped), 32'd1);
        do_reset("reset2");
`endif

        // Single pixel: request two edges after the push, then acked.
        tick(1'b1, 19'd5, 32'hAABB_CCDD, 1'b0, 1'b0, 1'b0, "t1.push");
        check("t1.nowrite", 32'(mem_write), 32'd0);
        idle(1'b0, "t1.wait");
        check("t1.req", 32'(mem_write), 32'd1);
        check("t1.addr", mem_addr, 32'h0000_1014);
        check("t1.data", mem_wdata, 32'hAABB_CCDD);
        idle(1'b1, "t1.ack");
        check("t1.done", 32'(mem_write), 32'd0);
        check("t1.count", 32'(count), 32'd0);

        // Fill: one entry moves into the pending request, so nine pushes leave eight queued.
        for (int i = 0; i < 9; i++)
            tick(1'b1, 19'(100 + i), 32'hC0DE_0000 + 32'(i), 1'b0, 1'b0, 1'b0, "t2.fill");
        check("t2.full_count", 32'(count), 32'd8);
        check("t2.not_ready", 32'(pixel_ready), 32'd0);
        tick(1'b1, 19'd999, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, "t2.ovf");
        check("t2.overflow", 32'(overflow), 32'd1);
        check("t2.count_held", 32'(count), 32'd8);
        wr_log.delete();
        wr_cyc.delete();
        for (int i = 0; i < 11; i++) idle(1'b1, "t2.drain");
        check("t2.writes", 32'(wr_log.size()), 32'd9);
        for (int i = 0; i < 9; i++) begin
            entry = (i < wr_log.size()) ? wr_log[i] : 64'd0;
            check("t2.order_addr", entry[63:32], fb_addr(19'(100 + i)));
            check("t2.order_data", entry[31:0], 32'hC0DE_0000 + 32'(i));
        end
        if (wr_cyc.size() == 9) check("t2.gapless", wr_cyc[8] - wr_cyc[0], 32'd8);

        // Streaming with a permanently acknowledging memory.
        wr_log.delete();
        wr_cyc.delete();
        for (int i = 0; i < 20; i++) begin
            exp_p[i] = 19'(2000 + 7 * i);
            exp_c[i] = $urandom;
            tick(1'b1, exp_p[i], exp_c[i], 1'b1, 1'b0, 1'b0, "t3.stream");
        end
        for (int i = 0; i < 4; i++) idle(1'b1, "t3.drain");
        check("t3.writes", 32'(wr_log.size()), 32'd20);
        if (wr_cyc.size() == 20) check("t3.gapless", wr_cyc[19] - wr_cyc[0], 32'd19);
        for (int i = 0; i < 20; i++) begin
            entry = (i < wr_log.size()) ? wr_log[i] : 64'd0;
            check("t3.addr", entry[63:32], fb_addr(exp_p[i]));
            check("t3.data", entry[31:0], exp_c[i]);
        end

        // Flush with slow acknowledges, then a flush on an already empty block.
        for (int i = 0; i < 3; i++)
            tick(1'b1, 19'(300 + i), 32'h0F0F_0000 + 32'(i), 1'b0, 1'b0, 1'b0, "t4.push");
        fd_cnt = 0;
        tick(1'b0, 19'd0, 32'd0, 1'b0, 1'b0, 1'b1, "t4.req");
        for (int w = 0; w < 3; w++) begin
            idle(1'b0, "t4.wait");
            idle(1'b0, "t4.wait");
            idle(1'b1, "t4.ack");
        end
        check("t4.done_after_last_ack", 32'(flush_done), 32'd1);
        for (int i = 0; i < 3; i++) idle(1'b0, "t4.after");
        check("t4.done_once", fd_cnt, 32'd1);
        tick(1'b0, 19'd0, 32'd0, 1'b0, 1'b0, 1'b1, "t4.empty_req");
        check("t4.empty_done", 32'(flush_done), 32'd1);
        idle(1'b0, "t4.empty_after");
        check("t4.empty_pulse", 32'(flush_done), 32'd0);

        // Clear while a write is pending: that write completes, the queue is discarded.
        for (int i = 0; i < 4; i++)
            tick(1'b1, 19'(400 + i), 32'h5A5A_0000 + 32'(i), 1'b0, 1'b0, 1'b0, "t5.push");
        tick(1'b0, 19'd0, 32'd0, 1'b0, 1'b1, 1'b0, "t5.clear");
        check("t5.count", 32'(count), 32'd0);
        check("t5.overflow", 32'(overflow), 32'd0);
        check("t5.held", 32'(mem_write), 32'd1);
        check("t5.held_addr", mem_addr, fb_addr(19'd400));
        wr_log.delete();
        for (int i = 0; i < 5; i++) idle(1'b1, "t5.drain");
        check("t5.writes", 32'(wr_log.size()), 32'd1);
        entry = (wr_log.size() > 0) ? wr_log[0] : 64'd0;
        check("t5.addr", entry[63:32], fb_addr(19'd400));

        // Asynchronous reset in the middle of a pending write.
        tick(1'b1, 19'd77, 32'h7777_7777, 1'b0, 1'b0, 1'b0, "t6.push");
        tick(1'b1, 19'd78, 32'h7878_7878, 1'b0, 1'b0, 1'b0, "t6.push");
        check("t6.busy", 32'(mem_write), 32'd1);
        do_reset("t6.reset");

        // Random traffic: a back-pressured half then a mostly-acknowledging half.
        for (int i = 0; i < 400; i++) begin
            tick(($urandom % 4) != 0,
                 19'($urandom_range(0, 32'h7FFFF)),
                 $urandom,
                 ($urandom % 4) < ((i < 200) ? 32'd1 : 32'd3),
                 ($urandom % 50) == 0,
                 ($urandom % 16) == 0,
                 "rnd");
        end
        for (int i = 0; i < 12; i++) idle(1'b1, "rnd.drain");
        check("end.idle", 32'(mem_write), 32'd0);
        check("end.empty", 32'(count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
